// File: rtl/move_repeat.sv
// rtl/move_repeat.sv - held left/right key levels to req/ack move requests with delayed auto-repeat (optional MOVE_REPEAT_SYNC_EN)
module move_repeat #(
    parameter int DAS_DELAY  = 8500000,
    parameter int ARR_PERIOD = 2500000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       left,
    input  logic       right,
    input  logic       move_ack,
    output logic       move_req,
    output logic       move_dir,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        D_NONE = 2'd0,
        D_L    = 2'd1,
        D_R    = 2'd2
    } dir_t;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

    logic left_s;
    logic right_s;

`ifdef MOVE_REPEAT_SYNC_EN
    logic [1:0] left_sync_q;
    logic [1:0] right_sync_q;

    // Two-flop synchronisers for key levels from another clock domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_sync_q  <= 2'b00;
            right_sync_q <= 2'b00;
        end else begin
            left_sync_q  <= {left_sync_q[0], left};
            right_sync_q <= {right_sync_q[0], right};
        end
    end

    assign left_s  = left_sync_q[1];
    assign right_s = right_sync_q[1];
`else
    assign left_s  = left;
    assign right_s = right;
`endif

    state_t           state_q, state_d;
    dir_t             prev_dir_q, cur_dir;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             dir_q, dir_d;
    logic             fire;

    // Both keys held cancel each other out, same as no key
    always_comb begin
        cur_dir = D_NONE;
        if (left_s && !right_s) begin
            cur_dir = D_L;
        end else if (right_s && !left_s) begin
            cur_dir = D_R;
        end
    end

    // Next-state: new press restarts the delay from any state; hold walks DELAY -> REPEAT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        if (cur_dir != D_NONE && cur_dir != prev_dir_q) begin
            state_d = S_DELAY;
            cnt_d   = '0;
            fire    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                end
                S_DELAY: begin
                    if (cur_dir == D_NONE) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DAS_LAST) begin
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (cur_dir == D_NONE) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == ARR_LAST) begin
                        cnt_d = '0;
                        fire  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Request handshake: a fire beats a same-cycle ack, and is dropped if the slot is still occupied
    always_comb begin
        req_d = req_q;
        dir_d = dir_q;
        if (fire && (!req_q || move_ack)) begin
            req_d = 1'b1;
            dir_d = (cur_dir == D_R);
        end else if (req_q && move_ack) begin
            req_d = 1'b0;
        end
    end

    // State, counter and handshake registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            prev_dir_q <= D_NONE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_dir_q <= cur_dir;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            dir_q      <= dir_d;
        end
    end

    assign move_req = req_q;
    assign move_dir = dir_q;
    assign state    = state_q;

endmodule
